canvas_write_arbiter: RTL and testbench



---
 rtl/canvas_pkg.sv | 20 ++
 rtl/canvas_write_arbiter_if.sv | 41 ++++
 rtl/raster_walker.sv | 50 +++++
 rtl/canvas_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_canvas_write_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/canvas_pkg.sv
// Shared types and helpers for the canvas frame-buffer write path.
// The address packing matches the frame buffer's {row, column} layout.
package canvas_pkg;
   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int X_W          = 10;
   localparam int Y_W          = 9;
   localparam int ADDR_W       = 19;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RECT  = 2'd2
   } canvas_state_e;

   function automatic logic [ADDR_W-1:0] pack_addr(input logic [Y_W-1:0] y,
                                                   input logic [X_W-1:0] x);
      return {y, x};
   endfunction
endpackage

// File: rtl/canvas_write_arbiter_if.sv
// Request and frame-buffer write signals of the canvas write arbiter.
// master = request sources and frame buffer side, slave = the arbiter.
interface canvas_write_arbiter_if;
   import canvas_pkg::*;

   logic                  clear_req;
   logic                  pen_valid;
   logic [X_W-1:0]        pen_x;
   logic [Y_W-1:0]        pen_y;
   logic                  pen_data;
   logic                  pen_ready;
   logic                  rect_start;
   logic [X_W-1:0]        rect_x0;
   logic [X_W-1:0]        rect_x1;
   logic [Y_W-1:0]        rect_y0;
   logic [Y_W-1:0]        rect_y1;
   logic                  rect_data;
   logic                  busy;
   logic                  clear_done;
   logic                  rect_done;
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic                  wr_data;
   canvas_state_e         dbg_state;

   // Pen handshake: a pen write transfers in every cycle where pen_valid and
   // pen_ready are both high; pen_ready never depends on pen_valid.
   modport master (
      output clear_req, pen_valid, pen_x, pen_y, pen_data,
      output rect_start, rect_x0, rect_x1, rect_y0, rect_y1, rect_data,
      input  pen_ready, busy, clear_done, rect_done, wr_en, wr_addr, wr_data,
      input  dbg_state
   );

   modport slave (
      input  clear_req, pen_valid, pen_x, pen_y, pen_data,
      input  rect_start, rect_x0, rect_x1, rect_y0, rect_y1, rect_data,
      output pen_ready, busy, clear_done, rect_done, wr_en, wr_addr, wr_data,
      output dbg_state
   );
endinterface

// File: rtl/raster_walker.sv
// Row-major raster position generator over an inclusive rectangle.
// Reset parks it on the full canvas so a power-on clear can start immediately.
module raster_walker
   import canvas_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic           step,
   input  logic           hold,
   input  logic [X_W-1:0] x0,
   input  logic [X_W-1:0] x1,
   input  logic [Y_W-1:0] y0,
   input  logic [Y_W-1:0] y1,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);
   logic [X_W-1:0] x_start;
   logic [X_W-1:0] x_end;
   logic [Y_W-1:0] y_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         x       <= '0;
         y       <= '0;
         x_start <= '0;
         x_end   <= X_W'(H_ACTIVE - 1);
         y_end   <= Y_W'(V_ACTIVE - 1);
      end else if (load) begin
         x       <= x0;
         y       <= y0;
         x_start <= x0;
         x_end   <= x1;
         y_end   <= y1;
      end else if (step && !hold) begin
         if (x == x_end) begin
            x <= x_start;
            y <= y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   assign last = (x == x_end) && (y == y_end);
endmodule

// File: rtl/canvas_write_arbiter.sv
// Single write port of the canvas frame buffer shared by pen, rectangle fill
// and full clear; one write per cycle with clear > pen > fill priority.
module canvas_write_arbiter
   import canvas_pkg::*;
#(
   parameter int   H_ACTIVE       = H_ACTIVE_DEF,
   parameter int   V_ACTIVE       = V_ACTIVE_DEF,
   parameter logic CLEAR_VALUE    = 1'b0,
   parameter bit   CLEAR_ON_RESET = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   canvas_write_arbiter_if.slave bus
);
   localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);

   canvas_state_e     state_q, state_d;
   logic [X_W-1:0]    w_x, w_x0, w_x1, x1_clamped;
   logic [Y_W-1:0]    w_y, w_y0, w_y1, y1_clamped;
   logic              w_last, w_load, w_step, w_hold;
   logic              rect_empty, clear_load, rect_latch;
   logic              pen_ready, pen_acc, pen_write;
   logic              fill_emit, fill_data, rect_data_q;
   logic              clear_done_d, rect_done_d;
   logic              wr_en_q, wr_data_q, busy_q, clear_done_q, rect_done_q;
   logic [ADDR_W-1:0] wr_addr_q;

   assign x1_clamped = (bus.rect_x1 > X_MAX) ? X_MAX : bus.rect_x1;
   assign y1_clamped = (bus.rect_y1 > Y_MAX) ? Y_MAX : bus.rect_y1;
   assign rect_empty = (bus.rect_x0 > x1_clamped) || (bus.rect_y0 > y1_clamped);

   assign pen_ready = !rst && (state_q != ST_CLEAR);
   assign pen_acc   = bus.pen_valid && pen_ready;
   assign pen_write = pen_acc && (bus.pen_x < X_W'(H_ACTIVE)) && (bus.pen_y < Y_W'(V_ACTIVE));

   always_comb begin
      state_d      = state_q;
      clear_load   = 1'b0;
      rect_latch   = 1'b0;
      w_load       = 1'b0;
      w_x0         = bus.rect_x0;
      w_y0         = bus.rect_y0;
      w_x1         = x1_clamped;
      w_y1         = y1_clamped;
      fill_emit    = 1'b0;
      fill_data    = rect_data_q;
      clear_done_d = 1'b0;
      rect_done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.clear_req) begin
               state_d    = ST_CLEAR;
               clear_load = 1'b1;
            end else if (bus.rect_start) begin
               if (rect_empty) begin
                  rect_done_d = 1'b1;
               end else begin
                  state_d    = ST_RECT;
                  w_load     = 1'b1;
                  rect_latch = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            fill_emit = 1'b1;
            fill_data = CLEAR_VALUE;
            if (w_last) begin
               clear_done_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         ST_RECT: begin
            if (bus.clear_req) begin
               state_d    = ST_CLEAR;
               clear_load = 1'b1;
            end else if (!bus.pen_valid) begin
               fill_emit = 1'b1;
               if (w_last) begin
                  rect_done_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A clear always walks the whole canvas regardless of the rect inputs.
      if (clear_load) begin
         w_load = 1'b1;
         w_x0   = '0;
         w_y0   = '0;
         w_x1   = X_MAX;
         w_y1   = Y_MAX;
      end
   end

   // The walker only advances in a cycle where its fill write is issued.
   assign w_step = (state_q != ST_IDLE);
   assign w_hold = (state_q == ST_RECT) && bus.pen_valid;

   raster_walker #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE)
   ) u_walker (
      .clk  (clk),
      .rst  (rst),
      .load (w_load),
      .step (w_step),
      .hold (w_hold),
      .x0   (w_x0),
      .x1   (w_x1),
      .y0   (w_y0),
      .y1   (w_y1),
      .x    (w_x),
      .y    (w_y),
      .last (w_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= 1'b0;
         clear_done_q <= 1'b0;
         rect_done_q  <= 1'b0;
         busy_q       <= CLEAR_ON_RESET;
         rect_data_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_en_q      <= fill_emit || pen_write;
         clear_done_q <= clear_done_d;
         rect_done_q  <= rect_done_d;
         busy_q       <= (state_d != ST_IDLE) || clear_done_d || rect_done_d;
         if (fill_emit) begin
            wr_addr_q <= pack_addr(w_y, w_x);
            wr_data_q <= fill_data;
         end else if (pen_write) begin
            wr_addr_q <= pack_addr(bus.pen_y, bus.pen_x);
            wr_data_q <= bus.pen_data;
         end
         if (rect_latch) rect_data_q <= bus.rect_data;
      end
   end

   assign bus.pen_ready  = pen_ready;
   assign bus.busy       = busy_q;
   assign bus.clear_done = clear_done_q;
   assign bus.rect_done  = rect_done_q;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_canvas_write_arbiter.sv
// Bench for canvas_write_arbiter on a reduced 64x48 canvas: per-cycle
// comparison against a queue-based reference model plus directed rect vectors.
module tb_canvas_write_arbiter;
   import canvas_pkg::*;

   localparam int   TH         = 64;
   localparam int   TV         = 48;
   localparam int   CLEAR_N    = TH * TV;
   localparam logic CLR_VAL    = 1'b0;
   localparam bit   CLR_ON_RST = 1'b1;
   localparam int   M_IDLE     = 0;
   localparam int   M_CLEAR    = 1;
   localparam int   M_RECT     = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   canvas_write_arbiter_if bus ();

   canvas_write_arbiter #(
      .H_ACTIVE       (TH),
      .V_ACTIVE       (TV),
      .CLEAR_VALUE    (CLR_VAL),
      .CLEAR_ON_RESET (CLR_ON_RST)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;
   int cyc_n  = 0;

   // Monitor tallies
   int          n_wr = 0, n_rd = 0, n_cd = 0, rd_cyc = 0;
   logic [18:0] last_addr = '0, rd_addr = '0, cd_addr = '0;
   logic        last_data = 1'b0;

   // Reference model: pending fill addresses in write order
   logic [18:0] exp_q[$];
   int          m_mode  = M_IDLE;
   logic        m_fdata = 1'b0;
   logic        e_we = 1'b0, e_data = 1'b0, e_cd = 1'b0, e_rd = 1'b0, e_busy = 1'b0;
   logic [18:0] e_addr = '0;

   typedef struct {
      int          x0, x1, y0, y1;
      logic        data;
      int          pen_at;
      int          fills, total, dur;
      logic [18:0] last;
   } rect_vec_t;
   rect_vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load_list(input int x0, input int x1, input int y0, input int y1);
      int xe, ye;
      xe = (x1 > TH - 1) ? TH - 1 : x1;
      ye = (y1 > TV - 1) ? TV - 1 : y1;
      exp_q.delete();
      for (int y = y0; y <= ye; y++)
         for (int x = x0; x <= xe; x++)
            exp_q.push_back({9'(y), 10'(x)});
   endtask

   task automatic model_step();
      e_we = 1'b0; e_cd = 1'b0; e_rd = 1'b0;
      if (rst) begin
         m_mode = CLR_ON_RST ? M_CLEAR : M_IDLE;
         load_list(0, TH - 1, 0, TV - 1);
         e_addr = '0; e_data = 1'b0; e_busy = CLR_ON_RST;
         return;
      end
      if (bus.pen_valid && m_mode != M_CLEAR && int'(bus.pen_x) < TH && int'(bus.pen_y) < TV) begin
         e_we = 1'b1; e_addr = {bus.pen_y, bus.pen_x}; e_data = bus.pen_data;
      end
      case (m_mode)
         M_IDLE: begin
            if (bus.clear_req) begin
               m_mode = M_CLEAR; load_list(0, TH - 1, 0, TV - 1);
            end else if (bus.rect_start) begin
               load_list(int'(bus.rect_x0), int'(bus.rect_x1), int'(bus.rect_y0), int'(bus.rect_y1));
               if (exp_q.size() == 0) e_rd = 1'b1;
               else begin m_mode = M_RECT; m_fdata = bus.rect_data; end
            end
         end
         M_CLEAR: begin
            e_we = 1'b1; e_addr = exp_q.pop_front(); e_data = CLR_VAL;
            if (exp_q.size() == 0) begin e_cd = 1'b1; m_mode = M_IDLE; end
         end
         default: begin
            if (bus.clear_req) begin
               m_mode = M_CLEAR; load_list(0, TH - 1, 0, TV - 1);
            end else if (!bus.pen_valid) begin
               e_we = 1'b1; e_addr = exp_q.pop_front(); e_data = m_fdata;
               if (exp_q.size() == 0) begin e_rd = 1'b1; m_mode = M_IDLE; end
            end
         end
      endcase
      e_busy = (m_mode != M_IDLE) || e_cd || e_rd;
   endtask

   // One clock: compare outputs mid-cycle, advance the model on the edge.
   task automatic cyc();
      @(negedge clk);
      if (chk_on) begin
         chk("wr_en", 32'(bus.wr_en), 32'(e_we));
         if (e_we) begin
            chk("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
            chk("wr_data", 32'(bus.wr_data), 32'(e_data));
         end
         chk("clear_done", 32'(bus.clear_done), 32'(e_cd));
         chk("rect_done", 32'(bus.rect_done), 32'(e_rd));
         chk("busy", 32'(bus.busy), 32'(e_busy));
         chk("pen_ready", 32'(bus.pen_ready), 32'(!rst && m_mode != M_CLEAR));
      end
      if (bus.wr_en) begin n_wr++; last_addr = bus.wr_addr; last_data = bus.wr_data; end
      if (bus.rect_done) begin n_rd++; rd_cyc = cyc_n; rd_addr = bus.wr_addr; end
      if (bus.clear_done) begin n_cd++; cd_addr = bus.wr_addr; end
      @(posedge clk);
      model_step();
      cyc_n++;
      #1;
   endtask

   task automatic idle_inputs();
      bus.pen_valid = 1'b0; bus.rect_start = 1'b0; bus.clear_req = 1'b0;
   endtask

   task automatic rand_pen(input int pct);
      bus.pen_valid = ($urandom_range(0, 99) < pct);
      bus.pen_x     = 10'($urandom_range(0, TH + 15));
      bus.pen_y     = 9'($urandom_range(0, TV + 11));
      bus.pen_data  = 1'($urandom_range(0, 1));
   endtask

   // noise 1: junk requests during a clear; noise 2: random pen during a fill
   task automatic run_until_idle(input int budget, input int noise, input string name);
      int i = 0;
      while (bus.busy && i < budget) begin
         if (noise == 1 && m_mode == M_CLEAR && exp_q.size() > 2) begin
            rand_pen(50);
            bus.rect_start = 1'($urandom_range(0, 1));
            bus.clear_req  = 1'($urandom_range(0, 1));
         end else if (noise == 2 && m_mode == M_RECT) begin
            rand_pen(25);
         end else begin
            idle_inputs();
         end
         cyc();
         i++;
      end
      idle_inputs();
      chk({name, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic start_rect(input int x0, input int x1, input int y0, input int y1, input logic d);
      bus.rect_x0 = 10'(x0); bus.rect_x1 = 10'(x1);
      bus.rect_y0 = 9'(y0);  bus.rect_y1 = 9'(y1);
      bus.rect_data = d; bus.rect_start = 1'b1;
      cyc();
      bus.rect_start = 1'b0;
   endtask

   initial begin
      int b_wr, b_rd, b_cd, s_cyc, x0, y0;
      vecs[0] = '{10, 12, 10, 11, 1'b1, 2, 6, 7, 7, {9'd11, 10'd12}};
      vecs[1] = '{54, 900, 38, 500, 1'b1, -1, 100, 100, 100, {9'd47, 10'd63}};
      vecs[2] = '{20, 10, 5, 5, 1'b1, -1, 0, 0, 0, 19'd0};
      vecs[3] = '{0, 0, 0, 0, 1'b0, -1, 1, 1, 1, 19'd0};
      vecs[4] = '{63, 63, 0, 47, 1'b1, -1, 48, 48, 48, {9'd47, 10'd63}};
      vecs[5] = '{0, 5, 30, 20, 1'b1, -1, 0, 0, 0, 19'd0};
      vecs[6] = '{100, 200, 0, 0, 1'b1, -1, 0, 0, 0, 19'd0};

      idle_inputs();
      bus.pen_x = '0; bus.pen_y = '0; bus.pen_data = 1'b0;
      bus.rect_x0 = '0; bus.rect_x1 = '0; bus.rect_y0 = '0; bus.rect_y1 = '0; bus.rect_data = 1'b0;

      // Reset and power-on clear
      cyc();
      chk_on = 1'b1;
      cyc(); cyc();
      chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
      b_wr = n_wr; b_cd = n_cd;
      rst = 1'b0;
      run_until_idle(CLEAR_N + 20, 1, "reset_clear");
      chk("reset_clear_writes", 32'(n_wr - b_wr), 32'(CLEAR_N));
      chk("reset_clear_done", 32'(n_cd - b_cd), 32'd1);
      chk("reset_clear_last", 32'(cd_addr), 32'({9'(TV - 1), 10'(TH - 1)}));

      // Pen in idle, in range then out of range
      b_wr = n_wr;
      bus.pen_valid = 1'b1; bus.pen_x = 10'd5; bus.pen_y = 9'd3; bus.pen_data = 1'b1;
      cyc(); bus.pen_valid = 1'b0; cyc(); cyc();
      chk("pen_idle_writes", 32'(n_wr - b_wr), 32'd1);
      chk("pen_idle_addr", 32'(last_addr), 32'({9'd3, 10'd5}));
      chk("pen_idle_data", 32'(last_data), 32'd1);
      b_wr = n_wr;
      bus.pen_valid = 1'b1; bus.pen_x = 10'd700;
      cyc(); bus.pen_valid = 1'b0; cyc(); cyc();
      chk("pen_oob_writes", 32'(n_wr - b_wr), 32'd0);

      // Rectangle vectors
      for (int v = 0; v < 7; v++) begin
         b_wr = n_wr; b_rd = n_rd;
         start_rect(vecs[v].x0, vecs[v].x1, vecs[v].y0, vecs[v].y1, vecs[v].data);
         s_cyc = cyc_n;
         if (vecs[v].pen_at >= 0) begin
            repeat (vecs[v].pen_at) cyc();
            bus.pen_valid = 1'b1; bus.pen_x = 10'd1; bus.pen_y = 9'd1; bus.pen_data = 1'b0;
            cyc();
            bus.pen_valid = 1'b0;
         end
         run_until_idle(2000, 0, "rect_vec");
         chk("rect_vec_writes", 32'(n_wr - b_wr), 32'(vecs[v].total));
         chk("rect_vec_done", 32'(n_rd - b_rd), 32'd1);
         chk("rect_vec_duration", 32'(rd_cyc - s_cyc), 32'(vecs[v].dur));
         if (vecs[v].fills > 0) chk("rect_vec_last", 32'(rd_addr), 32'(vecs[v].last));
      end

      // Clear aborts a fill in progress
      b_wr = n_wr; b_rd = n_rd; b_cd = n_cd;
      start_rect(0, 30, 0, 20, 1'b1);
      repeat (50) cyc();
      bus.clear_req = 1'b1; cyc(); bus.clear_req = 1'b0;
      run_until_idle(CLEAR_N + 50, 1, "abort");
      chk("abort_rect_done", 32'(n_rd - b_rd), 32'd0);
      chk("abort_clear_done", 32'(n_cd - b_cd), 32'd1);
      chk("abort_writes", 32'(n_wr - b_wr), 32'(50 + CLEAR_N));

      // Clear and rect requested together: clear wins
      b_wr = n_wr; b_rd = n_rd; b_cd = n_cd;
      bus.rect_x0 = 10'd0; bus.rect_x1 = 10'd3; bus.rect_y0 = 9'd0; bus.rect_y1 = 9'd3;
      bus.rect_start = 1'b1; bus.clear_req = 1'b1;
      cyc();
      idle_inputs();
      run_until_idle(CLEAR_N + 20, 1, "collision");
      chk("collision_rect_done", 32'(n_rd - b_rd), 32'd0);
      chk("collision_clear_done", 32'(n_cd - b_cd), 32'd1);
      chk("collision_writes", 32'(n_wr - b_wr), 32'(CLEAR_N));

      // Reset in the middle of a clear restarts it from address 0
      b_wr = n_wr; b_cd = n_cd;
      bus.clear_req = 1'b1; cyc(); bus.clear_req = 1'b0;
      repeat (100) cyc();
      rst = 1'b1; cyc(); rst = 1'b0;
      run_until_idle(CLEAR_N + 20, 0, "reset_mid");
      chk("reset_mid_clear_done", 32'(n_cd - b_cd), 32'd1);
      chk("reset_mid_writes", 32'(n_wr - b_wr), 32'(100 + CLEAR_N));

      // Randomized pen writes and fills
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 2))
            0: begin
               rand_pen(100); cyc(); idle_inputs(); cyc();
            end
            default: begin
               x0 = $urandom_range(0, TH + 4);
               y0 = $urandom_range(0, TV + 4);
               if ($urandom_range(0, 1) == 1) rand_pen(100);
               if ($urandom_range(0, 4) == 0)
                  start_rect(x0 + 3, x0, y0, y0 + $urandom_range(0, 4), 1'($urandom_range(0, 1)));
               else
                  start_rect(x0, x0 + $urandom_range(0, 6), y0, y0 + $urandom_range(0, 4),
                             1'($urandom_range(0, 1)));
               bus.pen_valid = 1'b0;
               run_until_idle(500, 2, "random_rect");
            end
         endcase
      end
      cyc(); cyc();
      chk("final_state", 32'(bus.dbg_state), 32'(ST_IDLE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
